soc_system_clkgen_multi: RTL and testbench
==========================================

Name: soc_system_clkgen_multi

Overview:
- Parametrised multi-output clock-enable generator. It sits downstream of the fabric PLL, is clocked by the PLL output and is qualified by the PLL lock flag.
- Provides NUM_CLOCKS independently programmable divided clocks, each with programmable duty and phase, plus matching one-cycle enable strobes.
- Filters the raw PLL lock flag and sequences a synchronous reset for downstream logic.
- Divider settings are reprogrammable at run time without glitches.

Parameters:
NUM_CLOCKS, 4, number of output channels (1..16)
DIV_W, 16, width of period/high/phase fields
LOCK_FILTER, 8, consecutive pll_locked cycles required before lock is declared (>=1)
RST_HOLD, 16, cycles rst_out stays high after locked rises (>=1)
DEFAULT_DIV, 2, reset value of every channel period

Ports:
refclk  in  1  block clock (PLL output domain)
rst  in  1  synchronous reset, active-high
pll_locked  in  1  raw PLL lock, already synchronous to refclk
cfg_wr  in  1  one-cycle config write strobe
cfg_ch  in  4  target channel index
cfg_div  in  DIV_W  period N in cycles
cfg_high  in  DIV_W  high-time H in cycles
cfg_phase  in  DIV_W  start offset P
outclk  out  NUM_CLOCKS  divided clock levels, registered
outclk_en  out  NUM_CLOCKS  one-cycle strobe per period, registered
locked  out  1  filtered lock
rst_out  out  1  downstream synchronous reset

Behaviour:
- Reset: all registers clear. outclk=0, outclk_en=0, locked=0, rst_out=1, lock FSM=UNLOCKED. Active and shadow N=DEFAULT_DIV, H=DEFAULT_DIV/2, P=0.
- Lock FSM:
  - UNLOCKED: qcnt=0. pll_locked=1 -> QUAL.
  - QUAL: qcnt increments each cycle pll_locked=1. At qcnt==LOCK_FILTER-1 -> LOCKED.
  - Any cycle with pll_locked=0, in any state -> UNLOCKED next cycle, with qcnt=0.
  - locked = (state==LOCKED), registered. Rises LOCK_FILTER cycles after pll_locked rises. Falls 1 cycle after pll_locked falls.
- rst_out: 1 while locked=0. After locked rises, stays 1 for RST_HOLD further cycles, then 0. Loss of lock reasserts rst_out on the same cycle locked falls; the hold counter restarts.
- Channel counter cnt[i], DIV_W bits:
  - While locked=0: cnt=P, outclk[i]=0, outclk_en[i]=0.
  - On the first locked cycle: cnt=P, with P>=N treated as 0.
  - Each subsequent cycle: cnt=(cnt+1) mod N.
  - Outputs update in the same cycle as cnt: outclk[i]=(cnt<H), outclk_en[i]=(cnt==0).
- Special cases:
  - N=0: channel disabled, outputs 0.
  - N=1: outclk_en=1 every cycle, outclk=(H>=1).
  - H>=N: outclk constant 1.
  - H=0: outclk constant 0.
- Config writes:
  - cfg_wr with cfg_ch<NUM_CLOCKS captures N/H/P into the channel's shadow registers. Writes with cfg_ch>=NUM_CLOCKS are ignored.
  - Shadow copies to active only at the period boundary: the cycle where cnt==N-1, so the next cycle starts at cnt=0 with the new N/H. The new P applies only at the next lock acquisition.
  - If the active N is 0 or 1, or locked=0, the shadow applies on the next cycle.
  - A second write before the boundary overwrites the shadow; last write wins.
  - Writes are accepted at any time, including while unlocked.
- Simultaneous events:
  - rst dominates everything.
  - Loss of lock dominates a pending config apply; the shadow is retained.
  - cfg_wr on the boundary cycle: the new value is captured into the shadow, and the old shadow is applied.
- All channels share lock gating, so channels with equal N start phase-aligned.

Test Plan:
- Lock qualification: rst 2 cycles; pll_locked=1 at cycle 10 -> locked=1 at cycle 18 (LOCK_FILTER=8); rst_out falls at cycle 34.
- Lock glitch: pll_locked drops for 1 cycle during QUAL at qcnt=5 -> locked stays 0 and requalifies a full 8 cycles after pll_locked returns. A drop while LOCKED -> locked=0 and rst_out=1 one cycle later, outputs 0.
- Divide/duty/phase: ch0 N=5 H=2 P=0, ch1 N=5 H=2 P=3 -> ch0 outclk pattern 11000 with en on the first cycle; ch1 starts at cnt=3, giving pattern 00110... with en 2 cycles after locked.
- Glitch-free retune: ch2 running N=4 H=2; write N=6 H=3 mid-period -> the current 4-cycle period completes unaltered, then 111000 repeats; no high/low pulse shorter than 2 cycles.
- Edge values: N=0 -> outputs constant 0; N=1 H=0 -> en constant 1, outclk 0; H=7 with N=4 -> outclk constant 1; P=9 with N=4 -> starts at cnt=0.
- Invalid and back-to-back writes: cfg_ch=7 with NUM_CLOCKS=4 -> no channel changes. Two writes to ch3 (N=8, then N=3) before the boundary -> only N=3 takes effect.

Source files
------------

// File: rtl/soc_system_clkgen_multi.sv
// soc_system_clkgen_multi: clock-enable generator that sits behind the fabric PLL.
// It filters the PLL lock flag, sequences a downstream reset, and drives
// NUM_CLOCKS divided clocks with programmable period, duty and phase. Each
// channel's divider settings can be changed at run time without glitches.

// One divider channel. Writes land in a shadow copy. The shadow becomes active
// at the end of a period, so an output pulse is never cut short.
module soc_system_clkgen_multi_ch #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2,
  parameter int CH_IDX      = 0
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,    // registered lock (current cycle)
  input  logic             lock_nxt,  // lock value the next cycle will carry
  input  logic             cfg_wr,
  input  logic [3:0]       cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_high,
  input  logic [DIV_W-1:0] cfg_phase,
  output logic             outclk,
  output logic             outclk_en
);

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] high;
    logic [DIV_W-1:0] phase;
  } cfg_t;

  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam cfg_t             CFG_RST = '{div:   DIV_W'(DEFAULT_DIV),
                                           high:  DIV_W'(DEFAULT_DIV / 2),
                                           phase: '0};

  cfg_t             shadow, active, act_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic             sel, boundary, apply;

  // cfg_ch values at or above NUM_CLOCKS match no instance, so those writes are ignored
  assign sel      = cfg_wr && (cfg_ch == 4'(CH_IDX));
  assign boundary = (active.div != '0) && (cnt == active.div - ONE);
  // Loss of lock holds off a boundary apply. The shadow is kept, and it is
  // picked up anyway on the following unlocked cycle.
  assign apply    = !locked || (lock_nxt && ((active.div <= ONE) || boundary));
  assign act_nxt  = apply ? shadow : active;

  // Next counter value: hold P while unlocked, load the clamped P on lock, otherwise wrap mod N
  always_comb begin
    cnt_nxt = act_nxt.phase;
    if (lock_nxt) begin
      if (!locked)
        cnt_nxt = (act_nxt.phase >= act_nxt.div) ? '0 : act_nxt.phase;
      else if (apply)
        cnt_nxt = '0;
      else
        cnt_nxt = cnt + ONE;
    end
  end

  // Shadow capture. The active copy takes the shadow only when apply allows it.
  always_ff @(posedge refclk) begin
    if (rst) begin
      shadow <= CFG_RST;
      active <= CFG_RST;
    end else begin
      if (sel) shadow <= {cfg_div, cfg_high, cfg_phase};
      active <= act_nxt;
    end
  end

  // Counter and outputs change on the same edge, so outclk/en follow the new cnt
  always_ff @(posedge refclk) begin
    if (rst) begin
      cnt       <= '0;
      outclk    <= 1'b0;
      outclk_en <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      outclk    <= lock_nxt && (act_nxt.div != '0) && (cnt_nxt < act_nxt.high);
      outclk_en <= lock_nxt && (act_nxt.div != '0) && (cnt_nxt == '0);
    end
  end

endmodule

module soc_system_clkgen_multi #(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_FILTER = 8,
  parameter int RST_HOLD    = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  cfg_wr,
  input  logic [3:0]            cfg_ch,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_high,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked,
  output logic                  rst_out
);

  typedef enum logic [1:0] {UNLOCKED, QUAL, LOCKED} lock_state_e;

  localparam int QW = $clog2(LOCK_FILTER + 1);
  localparam int HW = $clog2(RST_HOLD + 1);

  lock_state_e state, state_nxt;
  logic [QW-1:0] qcnt, qcnt_nxt;
  logic [HW-1:0] hcnt;
  logic          lock_nxt;

  // Lock FSM state register. locked is registered alongside it.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state  <= UNLOCKED;
      qcnt   <= '0;
      locked <= 1'b0;
    end else begin
      state  <= state_nxt;
      qcnt   <= qcnt_nxt;
      locked <= lock_nxt;
    end
  end

  // Lock qualification. qcnt counts the high cycles already seen, so
  // locked rises LOCK_FILTER cycles after pll_locked rises.
  always_comb begin
    state_nxt = state;
    qcnt_nxt  = qcnt;
    if (!pll_locked) begin
      state_nxt = UNLOCKED;
      qcnt_nxt  = '0;
    end else begin
      case (state)
        UNLOCKED, QUAL: begin
          if (qcnt == QW'(LOCK_FILTER - 1)) begin
            state_nxt = LOCKED;
          end else begin
            state_nxt = QUAL;
            qcnt_nxt  = qcnt + QW'(1);
          end
        end
        LOCKED:  state_nxt = LOCKED;
        default: begin
          state_nxt = UNLOCKED;
          qcnt_nxt  = '0;
        end
      endcase
    end
  end

  assign lock_nxt = (state_nxt == LOCKED);

  // Downstream reset. It is reasserted on the same edge that lock drops,
  // and released RST_HOLD cycles after locked rises.
  always_ff @(posedge refclk) begin
    if (rst) begin
      rst_out <= 1'b1;
      hcnt    <= '0;
    end else if (!lock_nxt) begin
      rst_out <= 1'b1;
      hcnt    <= '0;
    end else if (locked && rst_out) begin
      if (hcnt == HW'(RST_HOLD - 1)) rst_out <= 1'b0;
      else                           hcnt    <= hcnt + HW'(1);
    end
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
    soc_system_clkgen_multi_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .CH_IDX      (i)
    ) u_ch (
      .refclk    (refclk),
      .rst       (rst),
      .locked    (locked),
      .lock_nxt  (lock_nxt),
      .cfg_wr    (cfg_wr),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_high  (cfg_high),
      .cfg_phase (cfg_phase),
      .outclk    (outclk[i]),
      .outclk_en (outclk_en[i])
    );
  end

endmodule

// File: tb/tb_soc_system_clkgen_multi.sv
// Directed bench for soc_system_clkgen_multi. Cycle k is the interval after rising edge k.
module tb_soc_system_clkgen_multi;
  localparam int NC = 4;
  localparam int DW = 16;

  logic          refclk = 1'b0;
  logic          rst, pll_locked, cfg_wr;
  logic [3:0]    cfg_ch;
  logic [DW-1:0] cfg_div, cfg_high, cfg_phase;
  logic [NC-1:0] outclk, outclk_en;
  logic          locked, rst_out;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Hand-computed {ch3,ch2,ch1,ch0} per cycle from the first locked cycle.
  // ch0 N5H2P0, ch1 N5H2P3, ch2 N4H2P0, ch3 N0
  logic [3:0] exp_clk_a [10] = '{4'h5, 4'h5, 4'h2, 4'h2, 4'h4, 4'h5, 4'h1, 4'h2, 4'h6, 4'h4};
  logic [3:0] exp_en_a  [10] = '{4'h5, 4'h0, 4'h2, 4'h0, 4'h4, 4'h1, 4'h0, 4'h2, 4'h4, 4'h0};
  // After relock: ch0 N4H1P9, ch1 N4H7, ch2 N6H3, ch3 N1H0
  logic [3:0] exp_clk_b [4]  = '{4'h7, 4'h6, 4'h6, 4'h2};
  logic [3:0] exp_en_b  [4]  = '{4'hF, 4'h8, 4'h8, 4'h8};

  logic [11:0] rec_clk, rec_en;

  always #5 refclk = ~refclk;

  soc_system_clkgen_multi #(
    .NUM_CLOCKS (NC), .DIV_W (DW), .LOCK_FILTER (8), .RST_HOLD (16), .DEFAULT_DIV (2)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .cfg_wr     (cfg_wr),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_high   (cfg_high),
    .cfg_phase  (cfg_phase),
    .outclk     (outclk),
    .outclk_en  (outclk_en),
    .locked     (locked),
    .rst_out    (rst_out)
  );

  task automatic step();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cfg(input logic [3:0] ch, input int n, input int h, input int p);
    cfg_wr    = 1'b1;
    cfg_ch    = ch;
    cfg_div   = DW'(n);
    cfg_high  = DW'(h);
    cfg_phase = DW'(p);
    step();
    cfg_wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation ran past time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pll_locked = 1'b0; cfg_wr = 1'b0; cfg_ch = '0;
    cfg_div = '0; cfg_high = '0; cfg_phase = '0;
    step(); step();
    rst = 1'b0;                                   // cycle 2
    chk("rst_outclk", 32'(outclk), 0);
    chk("rst_en", 32'(outclk_en), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_rst_out", 32'(rst_out), 1);

    cfg(4'd0, 5, 2, 0);
    cfg(4'd1, 5, 2, 3);
    cfg(4'd2, 4, 2, 0);
    cfg(4'd3, 0, 0, 0);
    cfg(4'd7, 1, 1, 0);                           // invalid channel, must be ignored
    while (cyc < 10) step();
    pll_locked = 1'b1;
    while (cyc < 17) step();
    chk("lock_early", 32'(locked), 0);
    step();                                       // cycle 18
    chk("lock_rise", 32'(locked), 1);

    for (int t = 0; t < 10; t++) begin
      chk($sformatf("divpat_clk[%0d]", t), 32'(outclk), 32'(exp_clk_a[t]));
      chk($sformatf("divpat_en[%0d]", t), 32'(outclk_en), 32'(exp_en_a[t]));
      step();
    end

    while (cyc < 33) step();
    chk("rst_out_hold", 32'(rst_out), 1);
    step();                                       // cycle 34
    chk("rst_out_release", 32'(rst_out), 0);

    cfg(4'd2, 6, 3, 0);                           // ch2 mid-period retune (cnt=1 next)
    rec_clk = '0; rec_en = '0;
    for (int t = 0; t < 12; t++) begin
      rec_clk = {rec_clk[10:0], outclk[2]};
      rec_en  = {rec_en[10:0], outclk_en[2]};
      step();
    end
    chk("retune_clk", 32'(rec_clk), 32'h9C7);     // 1001_1100_0111
    chk("retune_en", 32'(rec_en), 32'h104);       // 0001_0000_0100

    cfg(4'd0, 4, 1, 9);
    cfg(4'd1, 4, 7, 0);
    cfg(4'd3, 1, 0, 0);
    step();                                       // cycle 51
    chk("n1_en", 32'(outclk_en[3]), 1);
    chk("n1_clk", 32'(outclk[3]), 0);

    pll_locked = 1'b0;
    step();                                       // cycle 52
    chk("drop_locked", 32'(locked), 0);
    chk("drop_rst_out", 32'(rst_out), 1);
    chk("drop_outclk", 32'(outclk), 0);
    chk("drop_en", 32'(outclk_en), 0);

    pll_locked = 1'b1;
    while (cyc < 57) step();
    pll_locked = 1'b0;                            // glitch at qcnt=5
    step();
    pll_locked = 1'b1;                            // cycle 58
    while (cyc < 60) step();
    chk("glitch_no_lock60", 32'(locked), 0);
    while (cyc < 65) step();
    chk("glitch_no_lock65", 32'(locked), 0);
    step();                                       // cycle 66
    chk("glitch_relock", 32'(locked), 1);
    chk("relock_rst_out", 32'(rst_out), 1);

    for (int t = 0; t < 4; t++) begin
      chk($sformatf("edge_clk[%0d]", t), 32'(outclk), 32'(exp_clk_b[t]));
      chk($sformatf("edge_en[%0d]", t), 32'(outclk_en), 32'(exp_en_b[t]));
      step();
    end

    cfg(4'd3, 5, 1, 0);                           // applies at once since active N=1
    step();                                       // cycle 72: ch3 cnt=0, N=5
    rec_clk = '0; rec_en = '0;
    for (int t = 0; t < 11; t++) begin
      rec_clk = {rec_clk[10:0], outclk[3]};
      rec_en  = {rec_en[10:0], outclk_en[3]};
      if (t == 0) begin
        cfg_wr = 1'b1; cfg_ch = 4'd3; cfg_div = 16'd8; cfg_high = 16'd4; cfg_phase = 16'd0;
      end else if (t == 1) begin
        cfg_wr = 1'b1; cfg_ch = 4'd3; cfg_div = 16'd3; cfg_high = 16'd1; cfg_phase = 16'd0;
      end
      step();
      cfg_wr = 1'b0;
    end
    chk("b2b_clk", 32'(rec_clk), 32'h424);        // 100_0010_0100
    chk("b2b_en", 32'(rec_en), 32'h424);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
